// File: rtl/ysyx_22041211_imm_pkg.sv
// Shared types and opcode constants for the IDU immediate decoder.
// The optional CSR-immediate decode is selected with YSYX_22041211_IMM_ZICSR_EN.
package ysyx_22041211_imm_pkg;

   typedef enum logic [2:0] {
      FMT_I = 3'd0,
      FMT_S = 3'd1,
      FMT_B = 3'd2,
      FMT_U = 3'd3,
      FMT_J = 3'd4,
      FMT_R = 3'd5,
      FMT_N = 3'd6,
      FMT_X = 3'd7
   } imm_fmt_e;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_TWO   = 2'd2
   } buf_state_e;

   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
   localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
   localparam logic [6:0] OPC_OP32     = 7'b0111011;

endpackage

// File: rtl/ysyx_22041211_imm_extract.sv
// Combinational opcode classifier and immediate extractor (inst -> imm, fmt, illegal).
// YSYX_22041211_IMM_ZICSR_EN enables non-zero immediates for SYSTEM-format words.
module ysyx_22041211_imm_extract
   import ysyx_22041211_imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst,
   output logic [XLEN-1:0] imm,
   output imm_fmt_e        fmt,
   output logic            illegal
);

   localparam bit RV64 = (XLEN == 64);

   // Every format is built as a signed 32-bit value and widened once at the end.
   logic signed [31:0] imm32;

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      imm32   = '0;
      fmt     = FMT_X;
      illegal = 1'b1;
      unique case (inst[6:0])
         OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
            fmt     = FMT_I;
            illegal = 1'b0;
            imm32   = {{20{inst[31]}}, inst[31:20]};
         end
         OPC_OP_IMM32: begin
            if (RV64) begin
               fmt     = FMT_I;
               illegal = 1'b0;
               imm32   = {{20{inst[31]}}, inst[31:20]};
            end
         end
         OPC_STORE: begin
            fmt     = FMT_S;
            illegal = 1'b0;
            imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         end
         OPC_BRANCH: begin
            fmt     = FMT_B;
            illegal = 1'b0;
            imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         end
         OPC_LUI, OPC_AUIPC: begin
            fmt     = FMT_U;
            illegal = 1'b0;
            imm32   = {inst[31:12], 12'b0};
         end
         OPC_JAL: begin
            fmt     = FMT_J;
            illegal = 1'b0;
            imm32   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         end
         OPC_OP: begin
            fmt     = FMT_R;
            illegal = 1'b0;
         end
         OPC_OP32: begin
            if (RV64) begin
               fmt     = FMT_R;
               illegal = 1'b0;
            end
         end
         OPC_SYSTEM: begin
            fmt     = FMT_N;
            illegal = 1'b0;
`ifdef YSYX_22041211_IMM_ZICSR_EN
            // csrr*i carries a 5-bit unsigned uimm in the rs1 field.
            if (inst[14]) imm32 = {27'd0, inst[19:15]};
            else          imm32 = {{20{inst[31]}}, inst[31:20]};
`else
            imm32 = '0;
`endif
         end
         default: ;
      endcase
   end

   // Size cast of a signed operand sign-extends to XLEN.
   assign imm = XLEN'(imm32);

endmodule

// File: rtl/ysyx_22041211_imm_decode_pipe.sv
// Registered immediate decoder with a two-entry skid buffer and saturating illegal counter.
// Build option: YSYX_22041211_IMM_ZICSR_EN (see ysyx_22041211_imm_extract).
module ysyx_22041211_imm_decode_pipe
   import ysyx_22041211_imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output imm_fmt_e         out_fmt,
   output logic             out_illegal,
   output logic [XLEN-1:0]  out_pc,
   output logic [CNT_W-1:0] illegal_cnt
);

   typedef struct packed {
      logic [XLEN-1:0] imm;
      imm_fmt_e        fmt;
      logic            illegal;
      logic [XLEN-1:0] pc;
   } entry_t;

   entry_t     in_entry;
   entry_t     main_q;
   entry_t     skid_q;
   buf_state_e state;
   logic       accept;
   logic       pop;

   ysyx_22041211_imm_extract #(
      .XLEN (XLEN)
   ) u_extract (
      .inst    (in_inst),
      .imm     (in_entry.imm),
      .fmt     (in_entry.fmt),
      .illegal (in_entry.illegal)
   );

   assign in_entry.pc = in_pc;

   assign in_ready  = !rst && (state != BUF_TWO);
   assign out_valid = (state != BUF_EMPTY);
   assign accept    = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // main_q always holds the oldest entry; skid_q only fills when main_q is stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the data registers are reset too, because out_* must read zero during reset.
         state  <= BUF_EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         unique case (state)
            BUF_EMPTY: begin
               if (accept) begin
                  main_q <= in_entry;
                  state  <= BUF_ONE;
               end
            end
            BUF_ONE: begin
               if (accept && pop) begin
                  main_q <= in_entry;
               end else if (accept) begin
                  skid_q <= in_entry;
                  state  <= BUF_TWO;
               end else if (pop) begin
                  state  <= BUF_EMPTY;
               end
            end
            BUF_TWO: begin
               if (pop) begin
                  main_q <= skid_q;
                  state  <= BUF_ONE;
               end
            end
            default: state <= BUF_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         illegal_cnt <= '0;
      end else if (accept && in_entry.illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
         illegal_cnt <= illegal_cnt + 1'b1;
      end
   end

   assign out_imm     = main_q.imm;
   assign out_fmt     = main_q.fmt;
   assign out_illegal = main_q.illegal;
   assign out_pc      = main_q.pc;

endmodule

// File: tb/tb_ysyx_22041211_imm_decode_pipe.sv
// Directed bench: an XLEN=32 decoder and an XLEN=64 decoder (2-bit counter) share one stimulus.
// Expected immediates below are hand-computed from the instruction encodings.
module tb_ysyx_22041211_imm_decode_pipe;
   import ysyx_22041211_imm_pkg::*;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_inst;
   logic [63:0] in_pc;
   logic        out_ready;

   logic        r32_ready, v32, ill32;
   logic [31:0] imm32, pc32;
   imm_fmt_e    fmt32;
   logic [15:0] cnt32;

   logic        r64_ready, v64, ill64;
   logic [63:0] imm64, pc64;
   imm_fmt_e    fmt64;
   logic [1:0]  cnt64;

   int total = 0;
   int bad   = 0;

   ysyx_22041211_imm_decode_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r32_ready),
      .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(v32), .out_ready(out_ready),
      .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_pc(pc32),
      .illegal_cnt(cnt32)
   );

   ysyx_22041211_imm_decode_pipe #(.XLEN(64), .CNT_W(2)) dut64 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r64_ready),
      .in_inst(in_inst), .in_pc(in_pc), .out_valid(v64), .out_ready(out_ready),
      .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_pc(pc64),
      .illegal_cnt(cnt64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] addi_word(input int k);
      return {12'(k), 5'd0, 3'b000, 5'd1, 7'b0010011};
   endfunction

   task automatic send(input logic [31:0] inst, input logic [63:0] pc);
      in_valid = 1'b1;
      in_inst  = inst;
      in_pc    = pc;
      step();
   endtask

   initial begin
      int idx;
      int got;
      int full_at;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_inst   = '0;
      in_pc     = '0;
      out_ready = 1'b0;
      step();
      check("rst_valid32", v32, 0);
      check("rst_valid64", v64, 0);
      check("rst_ready32", r32_ready, 0);
      check("rst_imm32", imm32, 0);
      check("rst_pc64", pc64, 0);
      check("rst_cnt32", cnt32, 0);
      step();
      rst = 1'b0;
      step();
      check("idle_ready32", r32_ready, 1);
      check("idle_valid32", v32, 0);

      // 1: addi -1
      out_ready = 1'b1;
      send(32'hFFF00093, 64'h100);
      check("t1_valid", v32, 1);
      check("t1_imm32", imm32, 64'hFFFFFFFF);
      check("t1_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
      check("t1_fmt", fmt32, FMT_I);
      check("t1_ill", ill32, 0);
      check("t1_pc", pc32, 64'h100);

      // 2: sw -4 then jal -8 back-to-back
      check("t2_ready_a", r32_ready, 1);
      send(32'hFE112E23, 64'h104);
      check("t2_imm_s", imm32, 64'hFFFFFFFC);
      check("t2_fmt_s", fmt32, FMT_S);
      check("t2_pc_s", pc32, 64'h104);
      check("t2_ready_b", r32_ready, 1);
      send(32'hFF9FF06F, 64'h108);
      check("t2_imm_j", imm32, 64'hFFFFFFF8);
      check("t2_fmt_j", fmt32, FMT_J);
      check("t2_imm_j64", imm64, 64'hFFFFFFFFFFFFFFF8);
      check("t2_ready_c", r32_ready, 1);

      // 3: lui sign extension on XLEN=64
      send(32'h800000B7, 64'h10C);
      check("t3_lui_neg64", imm64, 64'hFFFFFFFF80000000);
      check("t3_lui_neg32", imm32, 64'h80000000);
      check("t3_fmt", fmt64, FMT_U);
      send(32'h123450B7, 64'h110);
      check("t3_lui_pos64", imm64, 64'h0000000012345000);
      check("t3_lui_pos32", imm32, 64'h12345000);

      // branch with the smallest negative offset, and an R-type add
      send(32'hFE000FE3, 64'h114);
      check("b_imm32", imm32, 64'hFFFFFFFE);
      check("b_fmt", fmt32, FMT_B);
      send(32'h00B50533, 64'h118);
      check("r_imm", imm64, 0);
      check("r_fmt", fmt64, FMT_R);
      check("r_ill", ill32, 0);

      in_valid = 1'b0;
      step();
      check("drain_valid", v32, 0);

      // 4: five words, downstream stalled for the first three cycles
      idx     = 0;
      got     = 0;
      full_at = 99;
      for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
         in_valid  = (idx < 5);
         in_inst   = addi_word(idx + 1);
         in_pc     = 64'h200 + 64'(4 * idx);
         out_ready = (cyc >= 3);
         if (!r32_ready && full_at == 99) full_at = idx;
         if (v32 && out_ready) begin
            check($sformatf("t4_imm_%0d", got), imm32, 64'(got + 1));
            check($sformatf("t4_pc_%0d", got), pc32, 64'h200 + 64'(4 * got));
            check($sformatf("t4_pc64_%0d", got), pc64, 64'h200 + 64'(4 * got));
            got++;
         end
         if (in_valid && r32_ready) idx++;
         step();
      end
      in_valid = 1'b0;
      check("t4_full_after", 64'(full_at), 2);
      check("t4_all_out", 64'(got), 5);
      check("t4_empty", v32, 0);

      // 5: illegal words, counter saturation on the 2-bit instance, reset mid-stream
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         send(32'h00000000, 64'h300 + 64'(4 * k));
         check($sformatf("t5_ill_%0d", k), ill32, 1);
         check($sformatf("t5_fmt_%0d", k), fmt32, FMT_X);
         check($sformatf("t5_imm_%0d", k), imm32, 0);
      end
      check("t5_cnt32", cnt32, 3);
      check("t5_cnt64", cnt64, 3);
      send(32'h00000000, 64'h30C);
      check("t5_cnt32_4", cnt32, 4);
      check("t5_cnt64_sat", cnt64, 3);
      out_ready = 1'b0;
      send(32'h00000093, 64'h310);
      check("t5_full", r32_ready, 0);
      rst = 1'b1;
      #1;
      check("t5_rst_valid", v32, 0);
      check("t5_rst_valid64", v64, 0);
      check("t5_rst_cnt32", cnt32, 0);
      check("t5_rst_cnt64", cnt64, 0);
      check("t5_rst_ready", r32_ready, 0);
      in_valid = 1'b0;
      step();
      rst = 1'b0;
      step();
      check("t5_post_valid", v32, 0);

      // OP-32 is legal only on the XLEN=64 instance
      out_ready = 1'b1;
      send(32'h00B5053B, 64'h400);
      check("w_ill32", ill32, 1);
      check("w_fmt32", fmt32, FMT_X);
      check("w_ill64", ill64, 0);
      check("w_fmt64", fmt64, FMT_R);
      check("w_cnt32", cnt32, 1);
      check("w_cnt64", cnt64, 0);

      // 6: SYSTEM-format words
      send(32'h0002D073, 64'h404);
      check("t6_fmt", fmt32, FMT_N);
      check("t6_ill", ill32, 0);
`ifdef YSYX_22041211_IMM_ZICSR_EN
      check("t6_csrrwi", imm32, 5);
`else
      check("t6_csrrwi", imm32, 0);
`endif
      send(32'h00100073, 64'h408);
      check("t6_ebreak_fmt", fmt64, FMT_N);
`ifdef YSYX_22041211_IMM_ZICSR_EN
      check("t6_ebreak", imm64, 1);
`else
      check("t6_ebreak", imm64, 0);
`endif
      in_valid = 1'b0;
      step();
      check("end_empty", v32, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
